// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one TCDM-style L2 data master port among
// N_PORTS fabric-controller requesters. The request path is purely
// combinational. The requester index of every granted transaction is queued
// so that in-order L2 responses can be steered back to their owner.
module fc_l2_port_arbiter #(
  parameter int N_PORTS         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  // requester side
  input  logic [N_PORTS-1:0]                      slv_req_i,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]      slv_add_i,
  input  logic [N_PORTS-1:0]                      slv_wen_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]      slv_wdata_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]    slv_be_i,
  output logic [N_PORTS-1:0]                      slv_gnt_o,
  output logic [N_PORTS-1:0]                      slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]                   slv_r_rdata_o,
  // shared L2 master side
  output logic                                    mst_req_o,
  output logic [ADDR_WIDTH-1:0]                   mst_add_o,
  output logic                                    mst_wen_o,
  output logic [DATA_WIDTH-1:0]                   mst_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 mst_be_o,
  input  logic                                    mst_gnt_i,
  input  logic                                    mst_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                   mst_r_rdata_i,
  // sticky: a response arrived with nothing outstanding
  output logic                                    err_o
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  idx_t             rr_ptr_q;
  idx_t             winner;
  logic             any_req;
  idx_t             fifo_mem [MAX_OUTSTANDING];
  ptr_t             head_q;
  ptr_t             tail_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Pick the first active requester at or above rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!any_req && slv_req_i[idx]) begin
        any_req = 1'b1;
        winner  = idx_t'(idx);
      end
    end
  end

  // Full is judged on the registered count only: a pop in the same cycle
  // does not free a slot until the next edge.
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  assign mst_req_o  = any_req & ~fifo_full;
  assign push       = mst_req_o & mst_gnt_i;
  assign pop        = mst_r_valid_i & ~fifo_empty;

  // With no request, winner stays 0, so the port-0 fields are presented.
  assign mst_add_o     = slv_add_i[winner];
  assign mst_wen_o     = slv_wen_i[winner];
  assign mst_wdata_o   = slv_wdata_i[winner];
  assign mst_be_o      = slv_be_i[winner];
  assign slv_r_rdata_o = mst_r_rdata_i;
  assign err_o         = err_q;

  // Steer grant to the winner and the response to the oldest outstanding owner.
  always_comb begin
    slv_gnt_o     = '0;
    slv_r_valid_o = '0;
    if (push) slv_gnt_o[winner]           = 1'b1;
    if (pop)  slv_r_valid_o[fifo_mem[head_q]] = 1'b1;
  end

  // Round-robin pointer moves just past the winner on every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (winner == idx_t'(N_PORTS - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ID FIFO storage; only slots between head and tail are ever read.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; count_q alone defines which entries are valid.
    if (push) fifo_mem[tail_q] <= winner;
  end

  // ID FIFO pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= (tail_q == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + 1'b1;
      if (pop)  head_q <= (head_q == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error on any response that finds no transaction outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (mst_r_valid_i && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Bench for fc_l2_port_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model. Response routing is checked
// by a separate monitor that pops an expected-response scoreboard.
module tb_fc_l2_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  typedef struct {
    logic [N-1:0]  vec;
    logic [DW-1:0] data;
  } resp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          slv_req = '0;
  logic [N-1:0][AW-1:0]  slv_add = '0;
  logic [N-1:0]          slv_wen = '0;
  logic [N-1:0][DW-1:0]  slv_wdata = '0;
  logic [N-1:0][BW-1:0]  slv_be = '0;
  logic [N-1:0]          slv_gnt;
  logic [N-1:0]          slv_r_valid;
  logic [DW-1:0]         slv_r_rdata;
  logic                  mst_req;
  logic [AW-1:0]         mst_add;
  logic                  mst_wen;
  logic [DW-1:0]         mst_wdata;
  logic [BW-1:0]         mst_be;
  logic                  mst_gnt = 1'b0;
  logic                  mst_r_valid = 1'b0;
  logic [DW-1:0]         mst_r_rdata = '0;
  logic                  err_o;

  // reference model: outstanding owners in issue order, priority index, error flag
  int    m_q[$];
  int    m_rr;
  bit    m_err;
  resp_t exp_q[$];

  int n_vec;
  int n_miss;

  fc_l2_port_arbiter #(
    .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
    .slv_wdata_i(slv_wdata), .slv_be_i(slv_be),
    .slv_gnt_o(slv_gnt), .slv_r_valid_o(slv_r_valid), .slv_r_rdata_o(slv_r_rdata),
    .mst_req_o(mst_req), .mst_add_o(mst_add), .mst_wen_o(mst_wen),
    .mst_wdata_o(mst_wdata), .mst_be_o(mst_be),
    .mst_gnt_i(mst_gnt), .mst_r_valid_i(mst_r_valid), .mst_r_rdata_i(mst_r_rdata),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raise a request on port p with fresh random fields.
  task automatic set_port(input int p);
    slv_req[p]   = 1'b1;
    slv_add[p]   = $urandom;
    slv_wen[p]   = 1'($urandom);
    slv_wdata[p] = $urandom;
    slv_be[p]    = BW'($urandom);
  endtask

  // One clock cycle: drive L2 inputs, predict, check at negedge, advance model.
  task automatic step(input bit gnt, input bit rv, input logic [DW-1:0] rd);
    int           win;
    bit           any;
    bit           e_req;
    logic [N-1:0] e_gnt;
    resp_t        r;
    mst_gnt     = gnt;
    mst_r_valid = rv;
    mst_r_rdata = rd;
    any = 1'b0;
    win = 0;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_rr + k) % N;
      if (!any && slv_req[p]) begin
        any = 1'b1;
        win = p;
      end
    end
    e_req = any && (m_q.size() < MO);
    e_gnt = '0;
    if (e_req && gnt) e_gnt[win] = 1'b1;
    if (rv && m_q.size() > 0) begin
      r.vec          = '0;
      r.vec[m_q[0]]  = 1'b1;
      r.data         = rd;
      exp_q.push_back(r);
    end
    @(negedge clk);
    check("mst_req",   64'(mst_req),     64'(e_req));
    check("slv_gnt",   64'(slv_gnt),     64'(e_gnt));
    check("mst_add",   64'(mst_add),     64'(slv_add[win]));
    check("mst_wen",   64'(mst_wen),     64'(slv_wen[win]));
    check("mst_wdata", 64'(mst_wdata),   64'(slv_wdata[win]));
    check("mst_be",    64'(mst_be),      64'(slv_be[win]));
    check("rdata_bc",  64'(slv_r_rdata), 64'(rd));
    check("err",       64'(err_o),       64'(m_err));
    if (rv) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else                m_err = 1'b1;
    end
    if (e_req && gnt) begin
      m_q.push_back(win);
      m_rr = (win + 1) % N;
    end
    @(posedge clk);
    #1;
    if (e_req && gnt) slv_req[win] = 1'b0;
  endtask

  task automatic do_reset();
    slv_req     = '0;
    mst_gnt     = 1'b0;
    mst_r_valid = 1'b0;
    rst_n       = 1'b0;
    #2;
    check("err_async_clear", 64'(err_o),       64'(0));
    check("rvalid_in_reset", 64'(slv_r_valid), 64'(0));
    m_q.delete();
    m_rr  = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Return all outstanding responses.
  task automatic drain();
    slv_req = '0;
    for (int i = 0; i < 2 * MO; i++)
      if (m_q.size() > 0) step(1'b0, 1'b1, $urandom);
  endtask

  // Response monitor: every DUT response must match the oldest expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (slv_r_valid !== '0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL resp_unexpected: got valid %b expected none (t=%0t)", slv_r_valid, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_valid", 64'(slv_r_valid), 64'(e.vec));
          check("resp_rdata", 64'(slv_r_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    m_rr   = 0;
    m_err  = 1'b0;

    // single requester: port 1 read, response two cycles after grant
    do_reset();
    slv_req[1]   = 1'b1;
    slv_add[1]   = 32'h1C00_0010;
    slv_wen[1]   = 1'b1;
    slv_wdata[1] = '0;
    slv_be[1]    = '1;
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, '0);

    // fairness: ports 0 and 1 both request every cycle, L2 always grants
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (!slv_req[0]) set_port(0);
      if (!slv_req[1]) set_port(1);
      step(1'b1, c > 0, $urandom);
    end
    drain();

    // backpressure: port 0 held off for three cycles, then ports 0 and 1 compete
    do_reset();
    set_port(0);
    repeat (3) step(1'b0, 1'b0, '0);
    set_port(1);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    drain();

    // FIFO full: four reads outstanding, fifth blocked despite a same-cycle pop
    do_reset();
    for (int i = 0; i < MO; i++) begin
      set_port(0);
      step(1'b1, 1'b0, '0);
    end
    set_port(0);
    step(1'b1, 1'b1, $urandom);
    step(1'b1, 1'b0, '0);
    drain();

    // spurious response straight after reset; error sticks until reset
    do_reset();
    step(1'b0, 1'b1, $urandom);
    repeat (3) step(1'b0, 1'b0, '0);
    do_reset();
    step(1'b0, 1'b0, '0);

    // reset with two reads outstanding; priority must restart at port 0
    do_reset();
    set_port(0);
    set_port(1);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    do_reset();
    set_port(0);
    set_port(2);
    step(1'b1, 1'b0, '0);
    slv_req[2] = 1'b0;
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, '0);

    // randomized traffic: slow responses first to fill the FIFO, then faster
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 250) do_reset();
      for (int p = 0; p < N; p++)
        if (!slv_req[p] && ($urandom % 2 == 0)) set_port(p);
      step(($urandom % 4) != 0,
           (m_q.size() > 0) && ($urandom % ((c < 200) ? 5 : 2) == 0),
           $urandom);
    end
    drain();

    @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
